// File: rtl/wb_sched_pkg.sv
// Shared widths, constants and the write-back source encoding for the
// write-back scheduler and its arbiter.
package wb_sched_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int REG_NUM     = 32;

  localparam logic [RADDR_WIDTH-1:0] R_ZERO     = '0;
  localparam logic [DATA_WIDTH-1:0]  ZERO       = '0;
  localparam logic                   RST_ACTIVE = 1'b0;
  localparam logic                   WB_SRC_ALU = 1'b0;
  localparam logic                   WB_SRC_LSU = 1'b1;

  typedef enum logic {
    SRC_ALU = WB_SRC_ALU,
    SRC_LSU = WB_SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=LSU. The grant is
// combinational; last_gnt remembers the most recent winner for fairness.
module rr_arb2
  import wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output wb_src_e    last_gnt
);

  wb_src_e last_gnt_q;
  wb_src_e last_gnt_d;

  always_comb begin
    gnt        = 2'b00;
    last_gnt_d = last_gnt_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Under contention the source that did not win last time goes next.
      2'b11:   gnt = (last_gnt_q == SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      last_gnt_d = SRC_ALU;
    end else if (gnt[1]) begin
      last_gnt_d = SRC_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) begin
      last_gnt_q <= SRC_LSU;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign last_gnt = last_gnt_q;

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: shares the regfile write port between ALU and LSU and
// keeps a pending-destination scoreboard for RAW stalls and WAW issue blocking.
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = RADDR_WIDTH,
  parameter int REG_N  = REG_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic              rs1_en,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs2_en,
  output logic              raw_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  // Handshake: a source holds valid/rd/data stable until its ready is high;
  // the transfer happens in the cycle where valid && ready, and ready may
  // depend combinationally on valid. At most one ready is high per cycle.

  logic [1:0]        gnt;
  wb_src_e           last_gnt;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_fire;
  logic [REG_N-1:0]  clr_vec;
  logic [REG_N-1:0]  set_vec;
  logic [REG_N-1:0]  pending_q;
  logic [REG_N-1:0]  pending_d;
  logic              hit1;
  logic              hit2;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({lsu_valid, alu_valid}),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );

  always_comb begin
    wb_rd   = ADDR_W'(R_ZERO);
    wb_data = DATA_W'(ZERO);
    if (gnt[0]) begin
      wb_rd   = alu_rd;
      wb_data = alu_data;
    end else if (gnt[1]) begin
      wb_rd   = lsu_rd;
      wb_data = lsu_data;
    end
  end

  // r0 writes still complete the handshake but never reach the regfile.
  assign wb_fire   = (|gnt) && (wb_rd != ADDR_W'(R_ZERO));
  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign rf_wen    = wb_fire;
  assign rf_waddr  = wb_rd;
  assign rf_wdata  = wb_data;

  always_comb begin
    clr_vec = '0;
    if (wb_fire) begin
      clr_vec[wb_rd] = 1'b1;
    end
  end

  // A same-cycle write-back of the register is forwarded, so it is not a hazard.
  assign hit1 = clr_vec[rs1_addr];
  assign hit2 = clr_vec[rs2_addr];

  assign raw_stall =
      (rs1_en && (rs1_addr != ADDR_W'(R_ZERO)) && pending_q[rs1_addr] && !hit1) ||
      (rs2_en && (rs2_addr != ADDR_W'(R_ZERO)) && pending_q[rs2_addr] && !hit2);

  assign iss_ready = (iss_rd == ADDR_W'(R_ZERO)) || !pending_q[iss_rd] || clr_vec[iss_rd];

  always_comb begin
    set_vec = '0;
    if (iss_valid && iss_ready && (iss_rd != ADDR_W'(R_ZERO))) begin
      set_vec[iss_rd] = 1'b1;
    end
    // Set is applied after clear so a new issue to the same rd stays pending.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule
